// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the operand muxes, the control unit and the muldiv unit.
// The unit takes the slave side; the control unit (or bench) takes the master side.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] alu_in1;
  logic [XLEN-1:0] alu_in2;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, alu_in1, alu_in2,
    input  busy, valid, result
  );

  modport slave (
    input  start, op, alu_in1, alu_in2,
    output busy, valid, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: XLEN+1 cycles accept-to-valid, 1 cycle for div special cases.
// No backpressure: start is ignored while busy; the pipeline stalls on busy and takes result on valid.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [2*XLEN:0]   acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;

  logic              sgn1, sgn2, s1, s2, div0, ovf, accept;
  logic [XLEN-1:0]   abs1, abs2, spec_res;
  logic [XLEN:0]     mul_sum, trial;
  logic [2*XLEN:0]   shifted, step;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot, rem, quot_fix, rem_fix, calc_res;

  // Request decode: signedness, magnitudes and the division special cases.
  always_comb begin
    sgn1 = (bus.op != OP_MULHU) && (bus.op != OP_DIVU) && (bus.op != OP_REMU);
    sgn2 = sgn1 && (bus.op != OP_MULHSU);
    s1   = sgn1 && bus.alu_in1[XLEN-1];
    s2   = sgn2 && bus.alu_in2[XLEN-1];
    abs1 = s1 ? -bus.alu_in1 : bus.alu_in1;
    abs2 = s2 ? -bus.alu_in2 : bus.alu_in2;
    div0 = (bus.alu_in2 == '0);
    ovf  = !bus.op[0] && (bus.alu_in1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.alu_in2 == '1);
    if (div0) begin
      spec_res = bus.op[1] ? bus.alu_in1 : '1;
    end else begin
      spec_res = bus.op[1] ? '0 : bus.alu_in1;
    end
  end

  // One iteration. acc holds {hi/partial remainder (XLEN+1), multiplier/quotient (XLEN)}.
  always_comb begin
    mul_sum = acc_q[2*XLEN:XLEN] + {1'b0, b_q & {XLEN{acc_q[0]}}};
    shifted = {acc_q[2*XLEN-1:0], 1'b0};
    trial   = shifted[2*XLEN:XLEN] - {1'b0, b_q};
    if (op_q[2]) begin
      step = trial[XLEN] ? shifted : {trial, shifted[XLEN-1:1], 1'b1};
    end else begin
      step = {1'b0, mul_sum, acc_q[XLEN-1:1]};
    end

    prod     = step[2*XLEN-1:0];
    prod_fix = neg_q ? -prod : prod;
    quot     = step[XLEN-1:0];
    rem      = step[2*XLEN-1:XLEN];
    quot_fix = neg_q ? -quot : quot;
    rem_fix  = rneg_q ? -rem : rem;

    if (op_q[2]) begin
      calc_res = op_q[1] ? rem_fix : quot_fix;
    end else if (op_q == OP_MUL) begin
      calc_res = prod_fix[XLEN-1:0];
    end else begin
      calc_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    acc_d    = acc_q;
    b_d      = b_q;
    result_d = result_q;
    accept   = bus.start && (state_q != CALC);

    case (state_q)
      CALC: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          result_d = calc_res;
          state_d  = DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept, so back-to-back requests see no gap.
        state_d = IDLE;
        if (accept) begin
          op_d   = bus.op;
          neg_d  = s1 ^ s2;
          rneg_d = s1;
          cnt_d  = '0;
          b_d    = abs2;
          acc_d  = {{(XLEN+1){1'b0}}, abs1};
          if (bus.op[2] && (div0 || ovf)) begin
            result_d = spec_res;
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
    endcase

    busy_d  = (state_d == CALC);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= '0;
      b_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected result and latency queued at issue,
// popped and compared whenever valid is seen.
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [31:0] exp_res_q[$];
  int          exp_acc_q[$];
  int          exp_lat_q[$];
  string       exp_tag_q[$];

  muldiv_unit_if #(.XLEN(XLEN)) bus ();
  muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MUL:    begin p = sa * sb; return p[31:0];  end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM:    begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] corners [6];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0003};
    if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  // Called at a negedge; the following posedge is the accept edge.
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string tag);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.alu_in1 = a;
    bus.alu_in2 = b;
    exp_res_q.push_back(exp);
    exp_acc_q.push_back(cyc + 1);
    exp_lat_q.push_back(lat);
    exp_tag_q.push_back(tag);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string tag);
    @(negedge clk);
    drive(op, a, b, exp, lat, tag);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((exp_res_q.size() != 0 || bus.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat, input string tag);
    issue(op, a, b, exp, lat, tag);
    wait_done(tag);
  endtask

  always @(posedge clk) begin
    #1;
    if (bus.valid === 1'b1) begin
      if (exp_res_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        logic [31:0] r;
        int          a, l;
        string       t;
        r = exp_res_q.pop_front();
        a = exp_acc_q.pop_front();
        l = exp_lat_q.pop_front();
        t = exp_tag_q.pop_front();
        check({t, "_res"}, bus.result, r);
        check({t, "_lat"}, cyc - a + 1, l);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start   = 1'b0;
    bus.op      = 3'd0;
    bus.alu_in1 = '0;
    bus.alu_in2 = '0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_result", bus.result, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run(MUL,   32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
    run(MULH,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "mulh");
    run(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    run(DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, "div");
    run(REM,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, "rem");
    run(DIVU,  32'd100,       32'd7,         32'd14,        33, "divu");
    run(REMU,  32'd100,       32'd7,         32'd2,         33, "remu");
    run(DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "divu_by0");
    run(REM,   32'd5,         32'd0,         32'd5,         1,  "rem_by0");
    run(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
    run(REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1,  "rem_ovf");
    run(MUL,   32'h0,         32'h1234_5678, 32'h0,         33, "mul_zero");

    // start pulsed throughout CALC must not disturb the running operation
    issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "busy_ign");
    repeat (30) begin
      @(negedge clk);
      bus.start   = 1'b1;
      bus.op      = 3'($urandom_range(0, 7));
      bus.alu_in1 = $urandom;
      bus.alu_in2 = $urandom;
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("busy_ign");

    // back-to-back: second request presented during the DONE cycle
    begin
      int n;
      issue(MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "b2b_first");
      n = 0;
      while (bus.valid !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) check("b2b_wait_timeout", 0, 1);
      drive(DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, "b2b_second");
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("b2b");
    end

    run(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu");
    repeat (5) @(negedge clk);
    check("result_hold", bus.result, 32'hFFFF_FFFF);

    // reset after 10 iterations aborts without a valid pulse
    issue(MUL, 32'h0000_1234, 32'h0000_5678, 32'h0, 33, "aborted");
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_valid", bus.valid, 0);
    check("abort_result", bus.result, 0);
    void'(exp_res_q.pop_back());
    void'(exp_acc_q.pop_back());
    void'(exp_lat_q.pop_back());
    void'(exp_tag_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run(DIVU, 32'd100, 32'd7, 32'd14, 33, "after_abort");

    for (int i = 0; i < 12; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      run(op, a, b, model(op, a, b), model_lat(op, a, b), $sformatf("rnd%0d_op%0d", i, op));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide execution unit for the RV32M instructions.
- Sits directly downstream of the ALU operand muxes and consumes the same operand buses as the ALU: `alu_in1` from the first operand mux, `alu_in2` from the second operand mux.
- Produces one 32-bit result per operation after a multi-cycle computation.
- The control unit stalls the pipeline while `busy` is high and writes `result` back when `valid` pulses.

Parameters:
- XLEN, 32, operand and result width. Must equal REG_LEN.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only when the unit is not busy.
- op  input  3  operation select, latched on accept:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
- alu_in1  input  XLEN  operand 1 (rs1 value); latched on accept.
- alu_in2  input  XLEN  operand 2 (output of the ALU2 mux); latched on accept.
- busy  output  1  high while an operation is iterating.
- valid  output  1  single-cycle pulse; `result` is valid in this cycle.
- result  output  XLEN  registered result; holds its value until the next completion.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, valid=0, result=0, all internal registers 0.
  - Reset asserted mid-operation aborts it immediately.
  - No valid pulse is produced for an aborted operation.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 accepts the request: latch op and operands, compute operand signs and absolute values, set the iteration counter to 0.
  - Special division cases go directly to DONE.
  - All other cases go to CALC with busy=1.
- CALC: one iteration per clock, exactly XLEN iterations.
  - Multiply: shift-add on unsigned magnitudes into a 2*XLEN accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division on unsigned magnitudes, one quotient bit per cycle, MSB first. The partial remainder is XLEN+1 bits to hold the trial subtraction.
  - After iteration XLEN (counter == XLEN-1): apply sign fixup, load result, go to DONE, busy=0.
- DONE:
  - valid=1 for exactly this cycle.
  - start=1 in DONE is accepted exactly as in IDLE, allowing back-to-back operations. Otherwise the next state is IDLE.
- start while busy=1 is ignored. Operand changes during CALC have no effect.
- Latency:
  - Normal operation: start accepted at edge E0, iterations on edges E1..E_XLEN, valid high in the cycle following E_XLEN. This is XLEN+1 cycles from accept to valid.
  - Special cases: valid high in the cycle following E0.
- Signedness:
  - MUL, MULH: both operands signed.
  - MULHSU: operand 1 signed, operand 2 unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
  - DIV, REM: both operands signed.
- Result selection:
  - Product: negate the 2*XLEN product if the operand signs differ.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
  - Quotient: negated if the signs differ.
  - Remainder: takes the sign of the dividend.
- Special cases, resolved in IDLE/DONE without iterating:
  - Divide by zero (alu_in2==0): DIV/DIVU result is all ones; REM/REMU result is alu_in1.
  - Signed overflow (DIV/REM, alu_in1=0x80000000, alu_in2=0xFFFFFFFF): DIV result is 0x80000000, REM result is 0.
- Multiply by zero is not special-cased; it takes the full latency.
- result changes only on the edge that enters DONE.

Test Plan:
- Reset during CALC (after 10 iterations) -> busy=0, valid=0, result=0 on the next cycle; no valid pulse follows. A new start afterwards completes normally.
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> valid exactly 33 cycles after the accept edge, result=0xFFFFFFEB. MULH on the same operands -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -7 / 2 -> 0xFFFFFFFD (-3). REM -7 / 2 -> 0xFFFFFFFF (-1). DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, each with valid in the cycle after accept. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM on the same operands -> 0.
- Pulse start every cycle during CALC with different operands -> ignored; the first operation's result is unchanged. start held in the DONE cycle -> second operation accepted with no IDLE gap; its valid arrives 33 cycles later.
- MULHSU 0xFFFFFFFF (-1) x 0xFFFFFFFF (unsigned) -> 0xFFFFFFFF. result holds its value across subsequent idle cycles.
